nested_int_ctrl: RTL and testbench

- Three-level nested-priority interrupt controller inside top; receiving end of the inter1..inter3 request lines and driver of inter_running1..inter_running3.
- Latches request edges, arbitrates by priority (3 highest, 1 lowest), and hands one request at a time to the CPU via a req/ack handshake.
- Tracks nesting in an in-service register cleared by ERET, so a higher level preempts a lower one and a lower one waits.

---
 rtl/nested_int_ctrl_pkg.sv | 52 +++++
 rtl/nested_int_ctrl_if.sv | 30 +++
 rtl/nested_int_ctrl_int_edge_latch.sv | 32 +++
 rtl/nested_int_ctrl.sv | 146 ++++++++++++++
 tb/tb_nested_int_ctrl.sv | 410 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/nested_int_ctrl_pkg.sv
// Shared definitions for the nested interrupt controller: FSM states,
// level constants, vector defaults and small level helpers.
package nested_int_ctrl_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        REQ  = 1'b1
    } state_t;

    localparam logic [1:0] LVL_NONE = 2'd0;
    localparam logic [1:0] LVL1     = 2'd1;
    localparam logic [1:0] LVL2     = 2'd2;
    localparam logic [1:0] LVL3     = 2'd3;

    localparam logic [31:0] VEC_BASE_DEF   = 32'h0000_0400;
    localparam logic [31:0] VEC_STRIDE_DEF = 32'h0000_0040;

    // Highest set level in a 3-bit level mask (bit 2 = level 3), 0 if empty.
    function automatic logic [1:0] highest_level(input logic [2:0] bits);
        logic [1:0] lvl;
        lvl = LVL_NONE;
        if (bits[2]) begin
            lvl = LVL3;
        end else if (bits[1]) begin
            lvl = LVL2;
        end else if (bits[0]) begin
            lvl = LVL1;
        end
        return lvl;
    endfunction

    // One-hot mask for a level; level 0 maps to an empty mask.
    function automatic logic [2:0] level_onehot(input logic [1:0] lvl);
        logic [2:0] mask;
        mask = 3'b000;
        case (lvl)
            LVL1:    mask = 3'b001;
            LVL2:    mask = 3'b010;
            LVL3:    mask = 3'b100;
            default: mask = 3'b000;
        endcase
        return mask;
    endfunction

    // Handler address for a level.
    function automatic logic [31:0] vector_for(input logic [31:0] base,
                                               input logic [31:0] stride,
                                               input logic [1:0]  lvl);
        return base + (stride * {30'd0, lvl});
    endfunction

endpackage

// File: rtl/nested_int_ctrl_if.sv
// CPU-side handshake of the interrupt controller. The CPU is the master
// (enable, ack, eret); the controller is the slave presenting requests.
interface nested_int_ctrl_if;

    logic        int_en;
    logic        int_ack;
    logic        eret;
    logic        int_req;
    logic [1:0]  int_level;
    logic [31:0] int_vector;

    modport master (
        output int_en,
        output int_ack,
        output eret,
        input  int_req,
        input  int_level,
        input  int_vector
    );

    modport slave (
        input  int_en,
        input  int_ack,
        input  eret,
        output int_req,
        output int_level,
        output int_vector
    );

endinterface

// File: rtl/nested_int_ctrl_int_edge_latch.sv
// Per-source request latch: samples the external line, detects a rising
// edge and holds a pending bit until the level is acknowledged.
module int_edge_latch (
    input  logic clk,
    input  logic clr,
    input  logic i_src,
    input  logic i_clr_pend,
    output logic o_pend
);

    logic r_src_d;
    logic r_pend;

    // Edge history and pending bit; a new edge beats a same-cycle clear so
    // a fresh request arriving during the ack is not lost.
    always_ff @(posedge clk) begin
        if (clr) begin
            r_src_d <= 1'b0;
            r_pend  <= 1'b0;
        end else begin
            r_src_d <= i_src;
            if (i_src && !r_src_d) begin
                r_pend <= 1'b1;
            end else if (i_clr_pend) begin
                r_pend <= 1'b0;
            end
        end
    end

    assign o_pend = r_pend;

endmodule

// File: rtl/nested_int_ctrl.sv
// Three-level nested-priority interrupt controller. Requests are latched on
// rising edges, arbitrated against the highest in-service level and handed
// to the CPU one at a time through a req/ack handshake; ERET unwinds nesting.
module nested_int_ctrl
    import nested_int_ctrl_pkg::*;
#(
    parameter logic [31:0] VEC_BASE   = VEC_BASE_DEF,
    parameter logic [31:0] VEC_STRIDE = VEC_STRIDE_DEF,
    parameter int          CNT_W      = 32
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             inter1,
    input  logic             inter2,
    input  logic             inter3,
    nested_int_ctrl_if.slave cpu,
    output logic             inter_running1,
    output logic             inter_running2,
    output logic             inter_running3,
    output logic             eret_err,
    output logic [CNT_W-1:0] int_count
);

    logic [3:1]       w_src;
    logic [3:1]       w_pend;
    logic [3:1]       w_clr_pend;
    logic [3:1]       w_in_service_nxt;
    logic [1:0]       w_cur_pri;
    logic [1:0]       w_win;
    logic             w_eligible;
    logic             w_ack;

    state_t           r_state;
    logic             r_req;
    logic [1:0]       r_level;
    logic [31:0]      r_vector;
    logic [3:1]       r_in_service;
    logic             r_eret_err;
    logic [CNT_W-1:0] r_count;

    assign w_src = {inter3, inter2, inter1};

    for (genvar g = 1; g <= 3; g++) begin : g_src
        int_edge_latch u_latch (
            .clk        (clk),
            .clr        (clr),
            .i_src      (w_src[g]),
            .i_clr_pend (w_clr_pend[g]),
            .o_pend     (w_pend[g])
        );
    end

    assign w_cur_pri  = highest_level(r_in_service);
    assign w_win      = highest_level(w_pend);
    assign w_eligible = cpu.int_en && (w_win > w_cur_pri);
    assign w_ack      = (r_state == REQ) && cpu.int_ack;
    assign w_clr_pend = w_ack ? level_onehot(r_level) : 3'b000;

    // Next in-service mask: ERET retires the innermost level first, then an
    // ack in the same cycle marks its level, so a re-entered level survives.
    always_comb begin
        w_in_service_nxt = r_in_service;
        if (cpu.eret) begin
            w_in_service_nxt = w_in_service_nxt & ~level_onehot(w_cur_pri);
        end
        if (w_ack) begin
            w_in_service_nxt = w_in_service_nxt | level_onehot(r_level);
        end
    end

    // In-service register and the sticky flag for an ERET with nothing active.
    always_ff @(posedge clk) begin
        if (clr) begin
            r_in_service <= 3'b000;
            r_eret_err   <= 1'b0;
        end else begin
            r_in_service <= w_in_service_nxt;
            if (cpu.eret && (r_in_service == 3'b000)) begin
                r_eret_err <= 1'b1;
            end
        end
    end

    // Request FSM with registered req/level/vector; an ack always returns to
    // IDLE, which guarantees a one-cycle gap before the next request.
    always_ff @(posedge clk) begin
        if (clr) begin
            r_state  <= IDLE;
            r_req    <= 1'b0;
            r_level  <= LVL_NONE;
            r_vector <= 32'd0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_eligible) begin
                        r_state  <= REQ;
                        r_req    <= 1'b1;
                        r_level  <= w_win;
                        r_vector <= vector_for(VEC_BASE, VEC_STRIDE, w_win);
                    end
                end
                REQ: begin
                    if (cpu.int_ack) begin
                        r_state  <= IDLE;
                        r_req    <= 1'b0;
                        r_level  <= LVL_NONE;
                        r_vector <= 32'd0;
                    end else if (!cpu.int_en || (w_win <= w_cur_pri)) begin
                        r_state  <= IDLE;
                        r_req    <= 1'b0;
                        r_level  <= LVL_NONE;
                        r_vector <= 32'd0;
                    end else if (w_win > r_level) begin
                        r_level  <= w_win;
                        r_vector <= vector_for(VEC_BASE, VEC_STRIDE, w_win);
                    end
                end
                default: begin
                    r_state  <= IDLE;
                    r_req    <= 1'b0;
                    r_level  <= LVL_NONE;
                    r_vector <= 32'd0;
                end
            endcase
        end
    end

    // Accepted-interrupt counter, wrapping naturally at its width.
    always_ff @(posedge clk) begin
        if (clr) begin
            r_count <= '0;
        end else if (w_ack) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign cpu.int_req     = r_req;
    assign cpu.int_level   = r_level;
    assign cpu.int_vector  = r_vector;
    assign inter_running1  = r_in_service[1];
    assign inter_running2  = r_in_service[2];
    assign inter_running3  = r_in_service[3];
    assign eret_err        = r_eret_err;
    assign int_count       = r_count;

endmodule

// File: tb/tb_nested_int_ctrl.sv
// Testbench for nested_int_ctrl: directed scenario tasks plus a randomized
// run compared against a stack-based reference model of the controller.
module tb_nested_int_ctrl;

    logic        clk;
    logic        clr;
    logic        inter1, inter2, inter3;
    logic        running1, running2, running3;
    logic        eretErr;
    logic [31:0] intCount;

    int compared;
    int mismatched;
    int expCount;

    nested_int_ctrl_if cpuIf ();

    nested_int_ctrl dut (
        .clk            (clk),
        .clr            (clr),
        .inter1         (inter1),
        .inter2         (inter2),
        .inter3         (inter3),
        .cpu            (cpuIf.slave),
        .inter_running1 (running1),
        .inter_running2 (running2),
        .inter_running3 (running3),
        .eret_err       (eretErr),
        .int_count      (intCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: pending flags, an in-service stack, the offered request.
    bit          mPend [1:3];
    bit          mPrev [1:3];
    int          mStack [$];
    bit          mOffer;
    int          mOfferLvl;
    bit          mErr;
    int unsigned mCount;

    always @(posedge clk) begin
        bit inNow [1:3];
        int curPri;
        int win;
        bit ackTaken;
        inNow = '{inter1, inter2, inter3};
        if (clr) begin
            for (int n = 1; n <= 3; n++) begin
                mPend[n] = 1'b0;
                mPrev[n] = 1'b0;
            end
            mStack.delete();
            mOffer    = 1'b0;
            mOfferLvl = 0;
            mErr      = 1'b0;
            mCount    = 0;
        end else begin
            curPri = (mStack.size() > 0) ? mStack[$] : 0;
            win = 0;
            for (int n = 1; n <= 3; n++) if (mPend[n]) win = n;
            ackTaken = mOffer && cpuIf.int_ack;
            for (int n = 1; n <= 3; n++) begin
                if (inNow[n] && !mPrev[n]) mPend[n] = 1'b1;
                else if (ackTaken && n == mOfferLvl) mPend[n] = 1'b0;
                mPrev[n] = inNow[n];
            end
            if (cpuIf.eret) begin
                if (mStack.size() > 0) void'(mStack.pop_back());
                else mErr = 1'b1;
            end
            if (ackTaken) begin
                mStack.push_back(mOfferLvl);
                mCount++;
            end
            if (mOffer) begin
                if (ackTaken || !cpuIf.int_en || win <= curPri) mOffer = 1'b0;
                else mOfferLvl = win;
            end else if (cpuIf.int_en && win > curPri) begin
                mOffer    = 1'b1;
                mOfferLvl = win;
            end
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic pulse(input int lvl);
        if (lvl == 1) inter1 = 1'b1;
        if (lvl == 2) inter2 = 1'b1;
        if (lvl == 3) inter3 = 1'b1;
        tick();
        inter1 = 1'b0;
        inter2 = 1'b0;
        inter3 = 1'b0;
    endtask

    task automatic doAck();
        cpuIf.int_ack = 1'b1;
        tick();
        cpuIf.int_ack = 1'b0;
        expCount++;
    endtask

    task automatic doEret();
        cpuIf.eret = 1'b1;
        tick();
        cpuIf.eret = 1'b0;
    endtask

    task automatic test_reset();
        clr = 1'b1;
        tick();
        tick();
        compared++;
        if (cpuIf.int_req !== 1'b0 || cpuIf.int_level !== 2'd0 || cpuIf.int_vector !== 32'd0) begin
            mismatched++;
            $display("[TB] FAIL reset_outputs: got req=%0b lvl=%0d vec=%0h want 0/0/0", cpuIf.int_req, cpuIf.int_level, cpuIf.int_vector);
        end
        compared++;
        if ({running3, running2, running1, eretErr} !== 4'b0 || intCount !== 32'd0) begin
            mismatched++;
            $display("[TB] FAIL reset_state: got run=%b err=%0b cnt=%0d want 000/0/0", {running3, running2, running1}, eretErr, intCount);
        end
        clr = 1'b0;
        expCount = 0;
    endtask

    task automatic test_held_level();
        bit sawReq;
        cpuIf.int_en = 1'b1;
        inter1 = 1'b1;
        tick();
        tick();
        compared++;
        if (cpuIf.int_req !== 1'b1 || cpuIf.int_level !== 2'd1 || cpuIf.int_vector !== 32'h440) begin
            mismatched++;
            $display("[TB] FAIL held_first_req: got req=%0b lvl=%0d vec=%0h want 1/1/440", cpuIf.int_req, cpuIf.int_level, cpuIf.int_vector);
        end
        doAck();
        compared++;
        if (running1 !== 1'b1 || intCount !== expCount || cpuIf.int_req !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL held_ack: got run1=%0b cnt=%0d req=%0b want 1/%0d/0", running1, intCount, cpuIf.int_req, expCount);
        end
        sawReq = 1'b0;
        for (int i = 0; i < 77; i++) begin
            tick();
            if (cpuIf.int_req !== 1'b0) sawReq = 1'b1;
        end
        compared++;
        if (sawReq !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL held_no_second_req: got %0b want 0", sawReq);
        end
        inter1 = 1'b0;
        doEret();
        compared++;
        if (running1 !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL held_eret: got run1=%0b want 0", running1);
        end
    endtask

    task automatic test_preempt();
        pulse(1);
        tick();
        doAck();
        pulse(3);
        tick();
        compared++;
        if (cpuIf.int_req !== 1'b1 || cpuIf.int_level !== 2'd3 || cpuIf.int_vector !== 32'h4C0) begin
            mismatched++;
            $display("[TB] FAIL preempt_req: got req=%0b lvl=%0d vec=%0h want 1/3/4c0", cpuIf.int_req, cpuIf.int_level, cpuIf.int_vector);
        end
        doAck();
        compared++;
        if ({running3, running2, running1} !== 3'b101) begin
            mismatched++;
            $display("[TB] FAIL preempt_nested: got run=%b want 101", {running3, running2, running1});
        end
        doEret();
        compared++;
        if ({running3, running2, running1} !== 3'b001) begin
            mismatched++;
            $display("[TB] FAIL preempt_eret1: got run=%b want 001", {running3, running2, running1});
        end
        doEret();
        compared++;
        if ({running3, running2, running1} !== 3'b000 || intCount !== expCount) begin
            mismatched++;
            $display("[TB] FAIL preempt_eret2: got run=%b cnt=%0d want 000/%0d", {running3, running2, running1}, intCount, expCount);
        end
    endtask

    task automatic test_lower_waits();
        bit sawReq;
        pulse(3);
        tick();
        doAck();
        pulse(1);
        sawReq = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (cpuIf.int_req !== 1'b0) sawReq = 1'b1;
        end
        compared++;
        if (sawReq !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL lower_blocked: got %0b want 0", sawReq);
        end
        doEret();
        compared++;
        if (cpuIf.int_req !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL lower_after_eret_early: got req=%0b want 0", cpuIf.int_req);
        end
        tick();
        compared++;
        if (cpuIf.int_req !== 1'b1 || cpuIf.int_level !== 2'd1) begin
            mismatched++;
            $display("[TB] FAIL lower_presented: got req=%0b lvl=%0d want 1/1", cpuIf.int_req, cpuIf.int_level);
        end
        doAck();
        doEret();
    endtask

    task automatic test_upgrade();
        pulse(1);
        tick();
        doAck();
        pulse(2);
        tick();
        compared++;
        if (cpuIf.int_req !== 1'b1 || cpuIf.int_level !== 2'd2 || cpuIf.int_vector !== 32'h480) begin
            mismatched++;
            $display("[TB] FAIL upgrade_first: got req=%0b lvl=%0d vec=%0h want 1/2/480", cpuIf.int_req, cpuIf.int_level, cpuIf.int_vector);
        end
        pulse(3);
        tick();
        compared++;
        if (cpuIf.int_req !== 1'b1 || cpuIf.int_level !== 2'd3 || cpuIf.int_vector !== 32'h4C0) begin
            mismatched++;
            $display("[TB] FAIL upgrade_level: got req=%0b lvl=%0d vec=%0h want 1/3/4c0", cpuIf.int_req, cpuIf.int_level, cpuIf.int_vector);
        end
        doAck();
        doEret();
        tick();
        compared++;
        if (cpuIf.int_req !== 1'b1 || cpuIf.int_level !== 2'd2) begin
            mismatched++;
            $display("[TB] FAIL upgrade_pending2: got req=%0b lvl=%0d want 1/2", cpuIf.int_req, cpuIf.int_level);
        end
        doAck();
        doEret();
        doEret();
        compared++;
        if ({running3, running2, running1} !== 3'b000 || intCount !== expCount) begin
            mismatched++;
            $display("[TB] FAIL upgrade_cleanup: got run=%b cnt=%0d want 000/%0d", {running3, running2, running1}, intCount, expCount);
        end
    endtask

    task automatic test_eret_ack_same();
        pulse(1);
        tick();
        doAck();
        pulse(2);
        tick();
        cpuIf.eret = 1'b1;
        doAck();
        cpuIf.eret = 1'b0;
        compared++;
        if ({running3, running2, running1} !== 3'b010 || intCount !== expCount) begin
            mismatched++;
            $display("[TB] FAIL eret_ack_order: got run=%b cnt=%0d want 010/%0d", {running3, running2, running1}, intCount, expCount);
        end
        doEret();
    endtask

    task automatic test_eret_err();
        compared++;
        if (eretErr !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL eret_err_idle: got %0b want 0", eretErr);
        end
        doEret();
        compared++;
        if (eretErr !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL eret_err_set: got %0b want 1", eretErr);
        end
        for (int i = 0; i < 5; i++) tick();
        compared++;
        if (eretErr !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL eret_err_sticky: got %0b want 1", eretErr);
        end
    endtask

    task automatic test_reset_mid_req();
        bit sawReq;
        pulse(2);
        tick();
        doAck();
        pulse(3);
        tick();
        compared++;
        if (cpuIf.int_req !== 1'b1 || cpuIf.int_level !== 2'd3) begin
            mismatched++;
            $display("[TB] FAIL midreq_setup: got req=%0b lvl=%0d want 1/3", cpuIf.int_req, cpuIf.int_level);
        end
        clr = 1'b1;
        tick();
        clr = 1'b0;
        expCount = 0;
        compared++;
        if (cpuIf.int_req !== 1'b0 || cpuIf.int_level !== 2'd0 || cpuIf.int_vector !== 32'd0) begin
            mismatched++;
            $display("[TB] FAIL midreq_outputs: got req=%0b lvl=%0d vec=%0h want 0/0/0", cpuIf.int_req, cpuIf.int_level, cpuIf.int_vector);
        end
        compared++;
        if ({running3, running2, running1, eretErr} !== 4'b0 || intCount !== 32'd0) begin
            mismatched++;
            $display("[TB] FAIL midreq_state: got run=%b err=%0b cnt=%0d want 000/0/0", {running3, running2, running1}, eretErr, intCount);
        end
        sawReq = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (cpuIf.int_req !== 1'b0) sawReq = 1'b1;
        end
        compared++;
        if (sawReq !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL midreq_pend_cleared: got %0b want 0", sawReq);
        end
    endtask

    task automatic test_random();
        logic [31:0] expVec;
        logic [2:0]  expRun;
        clr = 1'b1;
        tick();
        clr = 1'b0;
        for (int cyc = 0; cyc < 1500; cyc++) begin
            tick();
            expVec = mOffer ? (32'h400 + 32'(mOfferLvl) * 32'h40) : 32'd0;
            expRun = 3'b000;
            foreach (mStack[k]) expRun[mStack[k] - 1] = 1'b1;
            compared++;
            if (cpuIf.int_req !== mOffer || cpuIf.int_level !== (mOffer ? 2'(mOfferLvl) : 2'd0) || cpuIf.int_vector !== expVec) begin
                mismatched++;
                $display("[TB] FAIL rand_req c%0d: got req=%0b lvl=%0d vec=%0h want %0b/%0d/%0h", cyc, cpuIf.int_req, cpuIf.int_level, cpuIf.int_vector, mOffer, mOffer ? mOfferLvl : 0, expVec);
            end
            compared++;
            if ({running3, running2, running1} !== expRun) begin
                mismatched++;
                $display("[TB] FAIL rand_running c%0d: got %b want %b", cyc, {running3, running2, running1}, expRun);
            end
            compared++;
            if (eretErr !== mErr || intCount !== mCount) begin
                mismatched++;
                $display("[TB] FAIL rand_err_cnt c%0d: got err=%0b cnt=%0d want %0b/%0d", cyc, eretErr, intCount, mErr, mCount);
            end
            if ($urandom_range(0, 3) == 0) inter1 = ~inter1;
            if ($urandom_range(0, 3) == 0) inter2 = ~inter2;
            if ($urandom_range(0, 5) == 0) inter3 = ~inter3;
            cpuIf.int_en  = ($urandom_range(0, 7) != 0);
            cpuIf.int_ack = ($urandom_range(0, 2) == 0);
            cpuIf.eret    = ($urandom_range(0, 6) == 0);
            clr           = ($urandom_range(0, 299) == 0);
        end
        clr           = 1'b0;
        inter1        = 1'b0;
        inter2        = 1'b0;
        inter3        = 1'b0;
        cpuIf.int_ack = 1'b0;
        cpuIf.eret    = 1'b0;
    endtask

    initial begin
        compared      = 0;
        mismatched    = 0;
        expCount      = 0;
        clr           = 1'b1;
        inter1        = 1'b0;
        inter2        = 1'b0;
        inter3        = 1'b0;
        cpuIf.int_en  = 1'b0;
        cpuIf.int_ack = 1'b0;
        cpuIf.eret    = 1'b0;
        $display("[TB] starting nested_int_ctrl bench");
        test_reset();
        test_held_level();
        test_preempt();
        test_lower_waits();
        test_upgrade();
        test_eret_ack_same();
        test_eret_err();
        test_reset_mid_req();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
